// File: rtl/serial_bit_source_pkg.sv
// Shared types and helpers for the serial bit source.
package serial_bit_source_pkg;

  localparam int unsigned DefaultWidth     = 20;
  localparam int unsigned DefaultBitCycles = 1;

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } state_e;

  // A length of zero, or one longer than the word, means "send the whole word".
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned width);
    return ((len == 0) || (len > width)) ? width : len;
  endfunction

endpackage

// File: rtl/bit_period_counter.sv
// Bit-period prescaler: tick marks the last clock of each bit period.
// With BIT_CYCLES == 1 every clock is a terminal clock, so no counter is built.
module bit_period_counter
  import serial_bit_source_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = DefaultBitCycles
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic run,
  output logic tick
);

  if (BIT_CYCLES > 1) begin : g_count
    localparam int unsigned   CntW    = $clog2(BIT_CYCLES);
    localparam logic [CntW-1:0] LastCnt = CntW'(BIT_CYCLES - 1);

    logic [CntW-1:0] count_q;

    // Count 0..BIT_CYCLES-1 while shifting; restart on a new word, park at 0 when idle.
    always_ff @(posedge clk) begin
      if (rst) begin
        count_q <= '0;
      end else if (start || !run || tick) begin
        count_q <= '0;
      end else begin
        count_q <= count_q + 1'b1;
      end
    end

    assign tick = (count_q == LastCnt);
  end else begin : g_bypass
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst, start, run};
    assign tick          = 1'b1;
  end

endmodule

// File: rtl/serial_bit_source.sv
// Parallel-to-serial stimulus source for the Moore sequence detector.
// Accepts a word over valid/ready and shifts it out MSB-first (bit in_len-1 first)
// on x, holding each bit for BIT_CYCLES clocks. done pulses on the final clock of
// the last bit, where in_ready is also high so a waiting word follows with no gap.
// Optional build macro: SERIAL_BIT_SOURCE_LOOP_EN adds loop_en, which replays the
// stored word when no new word is accepted at the word boundary.
module serial_bit_source
  import serial_bit_source_pkg::*;
#(
  parameter int unsigned  WIDTH      = DefaultWidth,
  parameter int unsigned  BIT_CYCLES = DefaultBitCycles,
  localparam int unsigned LEN_W      = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LEN_W-1:0] in_len,
  output logic             x,
  output logic             x_valid,
  output logic             done
`ifdef SERIAL_BIT_SOURCE_LOOP_EN
  ,
  input  logic             loop_en
`endif
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] last_idx_q, last_idx_d;
  logic             x_q, x_d;
  logic             x_valid_q, x_valid_d;

  logic             tick;
  logic             start;
  logic             last_bit;
  logic             accept;
  logic             loop_go;
  logic [IDX_W-1:0] in_first_idx;

  bit_period_counter #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_bit_period_counter (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .run   (state_q == StShift),
    .tick  (tick)
  );

`ifdef SERIAL_BIT_SOURCE_LOOP_EN
  assign loop_go = loop_en;
`else
  assign loop_go = 1'b0;
`endif

  // Index of the first bit to send for the offered word, after length clamping.
  assign in_first_idx = IDX_W'(clamp_len(32'(in_len), WIDTH) - 1);

  // Handshake and completion are decodes of registered state only.
  always_comb begin
    last_bit = (state_q == StShift) && (idx_q == '0) && tick;
    in_ready = (state_q == StIdle) || last_bit;
    done     = last_bit;
    accept   = in_valid && in_ready;
  end

  // Next-state: load on accept, step the bit index at each bit boundary,
  // and at the word boundary either take a new word, replay, or go idle.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    idx_d      = idx_q;
    last_idx_d = last_idx_q;
    start      = 1'b0;
    x_d        = 1'b0;
    x_valid_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d    = StShift;
          word_d     = in_data;
          idx_d      = in_first_idx;
          last_idx_d = in_first_idx;
          start      = 1'b1;
        end
      end
      StShift: begin
        if (last_bit) begin
          if (accept) begin
            word_d     = in_data;
            idx_d      = in_first_idx;
            last_idx_d = in_first_idx;
            start      = 1'b1;
          end else if (loop_go) begin
            idx_d = last_idx_q;
            start = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else if (tick) begin
          idx_d = idx_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // x follows the state being entered, so it is registered yet already valid
    // in the first cycle after an accept.
    if (state_d == StShift) begin
      x_d       = word_d[idx_d];
      x_valid_d = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      word_q     <= '0;
      idx_q      <= '0;
      last_idx_q <= '0;
      x_q        <= 1'b0;
      x_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      idx_q      <= idx_d;
      last_idx_q <= last_idx_d;
      x_q        <= x_d;
      x_valid_q  <= x_valid_d;
    end
  end

  assign x       = x_q;
  assign x_valid = x_valid_q;

endmodule

// File: doc/serial_bit_source.md
# serial_bit_source

Upstream stage of the Moore sequence detector: accepts a parallel word through a valid/ready handshake and shifts it out MSB-first as the detector's serial input `x`, one bit per bit period. It replaces hand-written stimulus with a synthesizable source, so on-board runs can drive arbitrary bit patterns into the detector's `x` pin from switches or a ROM.

## Interface
- `WIDTH`, 20, maximum word length in bits
- `BIT_CYCLES`, 1, clock cycles each bit is held on `x` (≥1)
- `LEN_W`, `$clog2(WIDTH+1)`, width of `in_len` (derived, not overridden)

- `clk`  in  1  rising-edge clock; one clock domain
- `rst`  in  1  reset, synchronous and active-high
- `in_valid`  in  1  word offered
- `in_ready`  out  1  block accepts a word this cycle
- `in_data`  in  WIDTH  word; bit `in_len-1` is sent first
- `in_len`  in  LEN_W  bits to send; 0 or >WIDTH treated as WIDTH
- `x`  out  1  serial bit to detector
- `x_valid`  out  1  `x` carries a payload bit
- `done`  out  1  one-cycle pulse, final cycle of last bit
- `loop_en`  in  1  present only with `SERIAL_BIT_SOURCE_LOOP_EN`

## Operation
- States: IDLE, SHIFT.
- Reset values: state IDLE, `x`=0, `x_valid`=0, `in_ready`=1, `done`=0, counters 0.
- Accept = `in_valid && in_ready` at a rising edge; word, clamped length, and bit index (len-1) are registered.
- SHIFT: `x` = word[idx], `x_valid`=1; bit timer counts 0..BIT_CYCLES-1; at terminal count idx decrements.
- Last bit, terminal cycle: `done`=1 and `in_ready`=1 in that same cycle.
  - Accept there → next cycle SHIFT with the new word's first bit (zero-gap back-to-back).
  - Otherwise → IDLE; `x`=0, `x_valid`=0.
- `in_ready`=0 in every other SHIFT cycle; `in_valid` ignored there.
- IDLE: `x` driven 0 (line idles low), `x_valid`=0.
- Outputs registered; no combinational path from inputs to `x`/`x_valid`/`done`. `in_ready` is a decode of registered state only.

## Timing
- Latency: accept at edge k → first bit on `x` during cycle k+1.
- Word occupies exactly `len*BIT_CYCLES` cycles; `done` in the last of them.
- Bit changes only at bit-period boundaries; `x` is stable for a full detector clock before its sampling edge.
- `rst` mid-word: next edge returns to reset values, no `done`, word discarded.
- `rst` and accept on the same edge: reset wins.
- `in_len`=1: single bit, `done` in its terminal cycle.

## Configuration
- `SERIAL_BIT_SOURCE_LOOP_EN` defined: `loop_en` port exists. On the last-bit terminal cycle with no accept and `loop_en`=1, the stored word restarts from bit len-1 with no gap; `done` still pulses each pass. A new accept has priority over looping. `loop_en` sampled only in that cycle.
- Undefined: no `loop_en` port; behaviour as Operation.

## Structure
- Package `serial_bit_source_pkg`: state enum (IDLE, SHIFT), length-clamp function, default `WIDTH`/`BIT_CYCLES` constants.
- Sub-module `bit_period_counter`: BIT_CYCLES prescaler with `start`, `tick` (terminal-count) outputs, reset to 0. Bypassed to constant `tick`=1 when BIT_CYCLES=1.

## Test plan
- Reset: hold `rst` 3 cycles → `x`=0, `x_valid`=0, `in_ready`=1, `done`=0.
- WIDTH=20, BIT_CYCLES=1, `in_data`=20'h8767B, `in_len`=20 → `x` = 1,0,0,0,0,1,1,1,0,1,1,0,0,1,1,1,1,0,1,1 on cycles k+1..k+20; `done` at k+20 only; detector `Z` matches golden model.
- Back-to-back: second word (`in_len`=4, data 4'b1010) held valid → accepted on first word's `done` cycle; `x`=1,0,1,0 immediately after, no idle gap.
- BIT_CYCLES=3, `in_len`=2, data 2'b10 → `x`=1 for 3 cycles, 0 for 3 cycles; `done` on cycle 6.
- `rst` asserted at bit 7 of a 20-bit word → `x`/`x_valid` 0 next cycle, no `done`, `in_ready`=1.
- Loop build, `loop_en`=1, `in_len`=3, data 3'b110 → `x` = 110110110…, `done` every 3rd cycle; new accept mid-stream takes over at the next word boundary.
